// File: rtl/tnet_pkg.sv
// Shared types for the timing-network command ingress path.
package tnet_pkg;

  // Field is tstamp because 'time' is a reserved word.
  typedef struct packed {
    logic [63:0]      header;
    logic [1:0][31:0] dt;
    logic [31:0]      tstamp;
  } TYPE_TNET_CMD;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_LOW
  } TYPE_ARB_ST;

endpackage

// File: rtl/tnet_cmd_fifo.sv
// Synchronous FIFO of timestamped commands; pointers carry one extra wrap bit.
module tnet_cmd_fifo
  import tnet_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         c_clk_i,
  input  logic         c_rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  TYPE_TNET_CMD din_i,
  input  logic         pop_i,
  output TYPE_TNET_CMD dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  TYPE_TNET_CMD    mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic            wr_en, rd_en;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Fullness is judged on the registered state, so a same-cycle pop never frees room.
  assign wr_en = push_i && !full_o && !clear_i;
  assign rd_en = pop_i && !empty_o && !clear_i;

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/tnet_cmd_arb.sv
// N-channel command ingress: per-channel FIFOs, round-robin grant, 4-phase req/ack to
// the command processor, saturating drop counters and a global flush.
module tnet_cmd_arb
  import tnet_pkg::*;
#(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                            c_clk_i,
  input  logic                            c_rst_i,
  input  logic [31:0]                     t_time_i,
  input  logic                            clear_i,
  input  logic [N_CH-1:0]                 ch_en_i,
  input  logic [N_CH-1:0]                 ch_set_i,
  input  logic [N_CH-1:0][63:0]           ch_header_i,
  input  logic [N_CH-1:0][1:0][31:0]      ch_dt_i,
  output logic                            cmd_req_o,
  output logic [63:0]                     cmd_header_o,
  output logic [1:0][31:0]                cmd_dt_o,
  output logic [$clog2(N_CH)-1:0]         cmd_ch_o,
  output logic [31:0]                     cmd_time_o,
  input  logic                            cmd_ack_i,
  output logic [N_CH-1:0]                 fifo_empty_o,
  output logic [N_CH-1:0]                 fifo_full_o,
  output logic [N_CH-1:0][CNT_W-1:0]      drop_cnt_o
);

  localparam int unsigned CH_W = $clog2(N_CH);

  TYPE_TNET_CMD                 fifo_din  [N_CH];
  TYPE_TNET_CMD                 fifo_head [N_CH];
  logic [N_CH-1:0]              push, pop, drop;
  TYPE_ARB_ST                   state_q, state_d;
  logic [CH_W-1:0]              last_q, sel_q, rr_idx, rr_cand;
  int unsigned                  rr_pos;
  logic                         rr_found, load;
  TYPE_TNET_CMD                 out_q;
  logic [N_CH-1:0][CNT_W-1:0]   drop_q;

  assign push = ch_set_i & ch_en_i;
  assign drop = push & fifo_full_o;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign fifo_din[i] = '{header: ch_header_i[i], dt: ch_dt_i[i], tstamp: t_time_i};

    tnet_cmd_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .c_clk_i (c_clk_i),
      .c_rst_i (c_rst_i),
      .clear_i (clear_i),
      .push_i  (push[i]),
      .din_i   (fifo_din[i]),
      .pop_i   (pop[i]),
      .dout_o  (fifo_head[i]),
      .full_o  (fifo_full_o[i]),
      .empty_o (fifo_empty_o[i])
    );
  end

  // Search begins one past the last-served channel and wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = 0;
    rr_cand  = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      rr_pos  = (32'(last_q) + k) % N_CH;
      rr_cand = CH_W'(rr_pos);
      if (!rr_found && !fifo_empty_o[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = '0;
    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cmd_ack_i) begin
          pop[sel_q] = 1'b1;
          state_d    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!cmd_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush abandons the in-flight command without popping it.
    if (clear_i) begin
      state_d = IDLE;
      load    = 1'b0;
      pop     = '0;
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      state_q <= IDLE;
      last_q  <= CH_W'(N_CH - 1);
      sel_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        last_q <= rr_idx;
        sel_q  <= rr_idx;
        out_q  <= fifo_head[rr_idx];
      end
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i || clear_i) begin
      drop_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (drop[i] && (drop_q[i] != '1)) drop_q[i] <= drop_q[i] + CNT_W'(1);
      end
    end
  end

  assign cmd_req_o    = (state_q == REQ);
  assign cmd_header_o = out_q.header;
  assign cmd_dt_o     = out_q.dt;
  assign cmd_time_o   = out_q.tstamp;
  assign cmd_ch_o     = sel_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_tnet_cmd_arb.sv
// Self-checking bench for tnet_cmd_arb: vector table for push/drop accounting, scoreboard of
// pushed commands compared at each grant, and hand-written handshake/flush/reset sequences.
module tb_tnet_cmd_arb;
  import tnet_pkg::*;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [31:0]                  t_time = '0;
  logic                         clear = 1'b0;
  logic [N_CH-1:0]              ch_en = '1;
  logic [N_CH-1:0]              ch_set = '0;
  logic [N_CH-1:0][63:0]        ch_header = '0;
  logic [N_CH-1:0][1:0][31:0]   ch_dt = '0;
  logic                         cmd_req;
  logic [63:0]                  cmd_header;
  logic [1:0][31:0]             cmd_dt;
  logic [1:0]                   cmd_ch;
  logic [31:0]                  cmd_time;
  logic                         ack = 1'b0;
  logic [N_CH-1:0]              fifo_empty, fifo_full;
  logic [N_CH-1:0][CNT_W-1:0]   drop_cnt;

  tnet_cmd_arb #(
    .N_CH (N_CH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .c_clk_i      (clk),
    .c_rst_i      (rst),
    .t_time_i     (t_time),
    .clear_i      (clear),
    .ch_en_i      (ch_en),
    .ch_set_i     (ch_set),
    .ch_header_i  (ch_header),
    .ch_dt_i      (ch_dt),
    .cmd_req_o    (cmd_req),
    .cmd_header_o (cmd_header),
    .cmd_dt_o     (cmd_dt),
    .cmd_ch_o     (cmd_ch),
    .cmd_time_o   (cmd_time),
    .cmd_ack_i    (ack),
    .fifo_empty_o (fifo_empty),
    .fifo_full_o  (fifo_full),
    .drop_cnt_o   (drop_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: every accepted push, in arrival order, tagged with its channel.
  typedef struct {
    int          ch;
    logic [63:0] hdr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] tm;
  } cmd_t;

  cmd_t sb[$];
  int   last_m = N_CH - 1;
  int   glog[$];

  function automatic int cnt_m(input int c);
    int n = 0;
    foreach (sb[i]) if (sb[i].ch == c) n++;
    return n;
  endfunction

  function automatic int find_m(input int c);
    foreach (sb[i]) if (sb[i].ch == c) return i;
    return -1;
  endfunction

  function automatic int rr_m();
    for (int k = 1; k <= N_CH; k++) begin
      int c = (last_m + k) % N_CH;
      if (cnt_m(c) > 0) return c;
    end
    return -1;
  endfunction

  // Grant monitor: each rising cmd_req is compared against the model's round-robin pick.
  logic req_prev = 1'b0;
  int   mon_c, mon_i;
  always @(negedge clk) begin
    if (cmd_req && !req_prev) begin
      mon_c = rr_m();
      glog.push_back(int'(cmd_ch));
      if (mon_c < 0) begin
        n_chk++;
        $display("FAIL grant_unexpected: got ch %0d, expected no grant", cmd_ch);
      end else begin
        mon_i = find_m(mon_c);
        check("grant_ch", 64'(cmd_ch), 64'(mon_c));
        check("grant_hdr", cmd_header, sb[mon_i].hdr);
        check("grant_dt0", 64'(cmd_dt[0]), 64'(sb[mon_i].d0));
        check("grant_dt1", 64'(cmd_dt[1]), 64'(sb[mon_i].d1));
        check("grant_time", 64'(cmd_time), 64'(sb[mon_i].tm));
        last_m = mon_c;
      end
    end
    req_prev = cmd_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of pushes; the model records what the DUT should accept.
  task automatic drive(input logic [N_CH-1:0] en, input logic [N_CH-1:0] set,
                       input logic [31:0] tm, input logic [63:0] hdr);
    ch_en  = en;
    ch_set = set;
    t_time = tm;
    for (int c = 0; c < N_CH; c++) begin
      ch_header[c] = hdr;
      ch_dt[c][0]  = tm + 32'(c);
      ch_dt[c][1]  = ~tm ^ 32'(c);
      if (en[c] && set[c] && !clear && cnt_m(c) < int'(DEPTH))
        sb.push_back('{c, hdr, tm + 32'(c), ~tm ^ 32'(c), tm});
    end
    tick();
    ch_set = '0;
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (cmd_req) ok = 1'b1;
    end
  endtask

  // Processor side: ack for len cycles once req is seen, checking req stays low throughout.
  task automatic serve(input int len);
    bit ok;
    int idx;
    wait_req(20, ok);
    if (!ok) begin
      n_chk++;
      $display("FAIL serve_timeout: got cmd_req 0 for 20 cycles, expected 1");
      return;
    end
    #1;
    idx = find_m(last_m);
    if (idx >= 0) sb.delete(idx);
    ack = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check("req_low_during_ack", 64'(cmd_req), 64'(0));
    end
    ack = 1'b0;
    @(negedge clk);
    check("req_low_after_ack", 64'(cmd_req), 64'(0));
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ch_set = '0;
    clear  = 1'b0;
    ack    = 1'b0;
    ch_en  = '1;
    tick();
    tick();
    sb.delete();
    glog.delete();
    last_m = N_CH - 1;
    rst    = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_req"}, 64'(cmd_req), 64'(0));
    check({tag, "_hdr"}, cmd_header, 64'(0));
    check({tag, "_dt"}, 64'(cmd_dt), 64'(0));
    check({tag, "_ch"}, 64'(cmd_ch), 64'(0));
    check({tag, "_time"}, 64'(cmd_time), 64'(0));
    check({tag, "_empty"}, 64'(fifo_empty), 64'(3'b111));
    check({tag, "_full"}, 64'(fifo_full), 64'(0));
    check({tag, "_drop"}, 64'(drop_cnt), 64'(0));
  endtask

  typedef struct {
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] set;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] full;
    logic [23:0]     drop;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Overflow on ch0 (DEPTH=4), a disabled-channel pulse, then a dual push.
    tbl[0] = '{3'b111, 3'b001, 3'b110, 3'b000, 24'h000000};
    tbl[1] = '{3'b111, 3'b001, 3'b110, 3'b000, 24'h000000};
    tbl[2] = '{3'b111, 3'b001, 3'b110, 3'b000, 24'h000000};
    tbl[3] = '{3'b111, 3'b001, 3'b110, 3'b001, 24'h000000};
    tbl[4] = '{3'b111, 3'b001, 3'b110, 3'b001, 24'h000001};
    tbl[5] = '{3'b111, 3'b001, 3'b110, 3'b001, 24'h000002};
    tbl[6] = '{3'b101, 3'b010, 3'b110, 3'b001, 24'h000002};
    tbl[7] = '{3'b111, 3'b110, 3'b000, 3'b001, 24'h000002};

    do_reset();
    check_idle_state("reset");

    // Single command on ch1 with timing of empty fall and req rise.
    drive(3'b111, 3'b010, 32'd100, 64'hA5A5_0000_0000_0001);
    check("single_empty_fall", 64'(fifo_empty), 64'(3'b101));
    check("single_req_not_yet", 64'(cmd_req), 64'(0));
    tick();
    check("single_req_t2", 64'(cmd_req), 64'(1));
    check("single_ch", 64'(cmd_ch), 64'(1));
    check("single_time", 64'(cmd_time), 64'(100));
    check("single_hdr", cmd_header, 64'hA5A5_0000_0000_0001);
    serve(1);
    tick();
    check("single_empty_after_pop", 64'(fifo_empty), 64'(3'b111));

    // Fairness: two identical three-way bursts, both granted 0,1,2.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      glog.delete();
      drive(3'b111, 3'b111, 32'(200 + b), 64'hB0B0_0000_0000_0000 + 64'(b));
      for (int g = 0; g < 3; g++) serve(1);
      for (int g = 0; g < 3; g++)
        check("fair_order", 64'(glog.size() > g ? glog[g] : -1), 64'(g));
    end

    // Vector table: push/drop accounting with no ack, then drain.
    do_reset();
    foreach (tbl[r]) begin
      drive(tbl[r].en, tbl[r].set, 32'(r + 1), 64'hC0C0_0000_0000_0000 + 64'(r));
      check("tbl_empty", 64'(fifo_empty), 64'(tbl[r].empty));
      check("tbl_full", 64'(fifo_full), 64'(tbl[r].full));
      check("tbl_drop", 64'(drop_cnt), 64'(tbl[r].drop));
    end
    for (int g = 0; g < 6; g++) serve(1);
    tick();
    check("drain_empty", 64'(fifo_empty), 64'(3'b111));
    check("drain_drop_kept", 64'(drop_cnt[0]), 64'(2));

    // Saturation on ch2, then pulses on disabled ch1.
    do_reset();
    for (int i = 0; i < 304; i++) drive(3'b111, 3'b100, 32'(1000 + i), 64'hD0D0);
    check("sat_drop2", 64'(drop_cnt[2]), 64'(255));
    check("sat_full2", 64'(fifo_full[2]), 64'(1));
    for (int i = 0; i < 5; i++) drive(3'b101, 3'b010, 32'(2000 + i), 64'hD1D1);
    check("dis_empty1", 64'(fifo_empty[1]), 64'(1));
    check("dis_drop1", 64'(drop_cnt[1]), 64'(0));

    // Flush while a command sits in REQ, with a same-cycle push that must be discarded.
    check("clr_req_before", 64'(cmd_req), 64'(1));
    clear = 1'b1;
    drive(3'b111, 3'b001, 32'd3000, 64'hE0E0);
    clear = 1'b0;
    sb.delete();
    check("clr_req_low", 64'(cmd_req), 64'(0));
    check("clr_empty", 64'(fifo_empty), 64'(3'b111));
    check("clr_full", 64'(fifo_full), 64'(0));
    check("clr_drop", 64'(drop_cnt), 64'(0));
    repeat (4) tick();
    check("clr_no_regrant", 64'(cmd_req), 64'(0));
    drive(3'b111, 3'b001, 32'd3100, 64'hE1E1);
    serve(1);

    // Long ack: exactly one pop, req held low until two cycles after ack falls.
    drive(3'b111, 3'b010, 32'd4000, 64'hF0F0_0000_0000_0001);
    drive(3'b111, 3'b010, 32'd4001, 64'hF0F0_0000_0000_0002);
    serve(5);
    check("hs_one_pop", 64'(fifo_empty[1]), 64'(0));
    serve(1);
    tick();
    check("hs_empty", 64'(fifo_empty), 64'(3'b111));

    // Reset in the middle of an outstanding request.
    drive(3'b111, 3'b111, 32'd5000, 64'h1234);
    tick();
    check("rst_req_before", 64'(cmd_req), 64'(1));
    rst = 1'b1;
    tick();
    check_idle_state("midrst");
    sb.delete();
    last_m = N_CH - 1;
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
